// File: rtl/dl_lshift_pipe_if.sv
// Handshake bundle for dl_lshift_pipe.
//   master : upstream/downstream environment (drives operands, flush, out_ready)
//   slave  : the shifter (drives in_ready, out_valid, out)
// Signals:
//   flush      synchronous kill of every in-flight operation
//   in_valid   operation presented
//   in_ready   shifter can take the operation this cycle
//   sh_type    0 = logical left shift, 1 = rotate left
//   in         operand
//   shamt      shift amount
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out        shifted result
interface dl_lshift_pipe_if #(
   parameter int unsigned NUM_BITS = 32
);
   localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS);

   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic                      sh_type;
   logic [NUM_BITS-1:0]       in;
   logic [NUM_SHIFT_BITS-1:0] shamt;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_BITS-1:0]       out;

   modport master (
      output flush, in_valid, sh_type, in, shamt, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  flush, in_valid, sh_type, in, shamt, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/dl_lshift_pipe.sv
// Pipelined left shifter / rotator with valid/ready handshakes.
// Stage i applies a shift of 2**i when shamt bit i is set; every stage is
// registered, so a result leaves NUM_SHIFT_BITS cycles after acceptance.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (clears valids and data)
//   bus    dl_lshift_pipe_if.slave: flush, in_valid/in_ready, sh_type, in,
//          shamt, out_valid/out_ready, out
// in_ready is combinational from out_ready; out/out_valid come from flops.
module dl_lshift_pipe #(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   dl_lshift_pipe_if.slave  bus
);

   localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS);
   localparam int unsigned NS             = NUM_SHIFT_BITS;
   // Stage i keeps NS-1-i shamt bits for the stages after it.
   localparam int unsigned REM_TOT        = (NS * (NS - 1)) / 2;

   // Bit offset of stage idx's remaining-shamt field inside rem_bus.
   function automatic int unsigned rem_off(input int unsigned idx);
      return (idx * (NS - 1)) - ((idx * idx - idx) / 2);
   endfunction

   logic [NS-1:0]       stage_valid;
   logic [NS-1:0]       stage_ready;
   logic [NUM_BITS-1:0] stage_data [NS];
   logic                stage_type [NS-1];
   logic [REM_TOT-1:0]  rem_bus;

   for (genvar i = 0; i < NS; i++) begin : g_stage
      localparam int unsigned SH   = 32'd1 << i;
      localparam int unsigned UP_W = NS - i;

      logic                valid_q, valid_d;
      logic [NUM_BITS-1:0] data_q, data_d;
      logic                up_valid;
      logic                up_type;
      logic [NUM_BITS-1:0] up_data;
      logic [UP_W-1:0]     up_rem;
      logic [NUM_BITS-1:0] shifted;
      logic                load;

      // Upstream source: input ports for stage 0, previous stage otherwise.
      if (i == 0) begin : g_src
         assign up_valid = bus.in_valid;
         assign up_type  = bus.sh_type;
         assign up_data  = bus.in;
         assign up_rem   = bus.shamt;
      end else begin : g_src
         localparam int unsigned UP_OFF = rem_off(i - 1);
         assign up_valid = stage_valid[i-1];
         assign up_type  = stage_type[i-1];
         assign up_data  = stage_data[i-1];
         assign up_rem   = rem_bus[UP_OFF +: UP_W];
      end

      // Ready chain unrolled: a stage can load if downstream drains or any
      // stage from here to the output is empty (bubble collapsing).
      assign stage_ready[i] = bus.out_ready || !(&stage_valid[NS-1:i]);
      assign load           = stage_ready[i] && up_valid;

      // Shift by 2**i, zero fill or wrap-around of the top bits.
      always_comb begin
         shifted = up_data;
         if (up_rem[0]) begin
            if (up_type) begin
               shifted = (up_data << SH) | (up_data >> (NUM_BITS - SH));
            end else begin
               shifted = up_data << SH;
            end
         end
      end

      // Next state: flush wins over any load; stalled stages hold.
      always_comb begin
         valid_d = valid_q;
         data_d  = data_q;
         if (stage_ready[i]) begin
            valid_d = up_valid;
         end
         if (load) begin
            data_d = shifted;
         end
         if (bus.flush) begin
            valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end

      assign stage_valid[i] = valid_q;
      assign stage_data[i]  = data_q;

      // Operation type and unused shamt bits only travel to later stages.
      if (i < NS - 1) begin : g_fwd
         localparam int unsigned REM_W = NS - 1 - i;
         localparam int unsigned OFF   = rem_off(i);

         logic             type_q, type_d;
         logic [REM_W-1:0] rem_q, rem_d;

         always_comb begin
            type_d = type_q;
            rem_d  = rem_q;
            if (load) begin
               type_d = up_type;
               rem_d  = up_rem[UP_W-1:1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               type_q <= 1'b0;
               rem_q  <= '0;
            end else begin
               type_q <= type_d;
               rem_q  <= rem_d;
            end
         end

         assign stage_type[i]         = type_q;
         assign rem_bus[OFF +: REM_W] = rem_q;
      end
   end

   assign bus.in_ready  = stage_ready[0];
   assign bus.out_valid = stage_valid[NS-1];
   assign bus.out       = stage_data[NS-1];

endmodule

// File: doc/dl_lshift_pipe.md
Name: dl_lshift_pipe

Overview:
- Pipelined, parameterized left shifter with valid/ready handshakes on input and output.
- Complement to the combinational right shifter: same shamt decomposition (stage i applies a shift of 2**i when shamt[i] is set), but each stage is registered.
- Sits in the execute path where a full-width combinational shift would limit timing.
- Supports logical left shift and rotate-left. A synchronous flush kills in-flight operations.

Parameters:
- NUM_BITS, 32, data width; must be a power of 2, >= 4.
- NUM_SHIFT_BITS, $clog2(NUM_BITS), localparam; shamt width and number of pipeline stages.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; clears all stage valids.
- in_valid  input  1  input operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- sh_type  input  1  0 = logical left shift (zero fill); 1 = rotate left.
- in  input  NUM_BITS  operand.
- shamt  input  NUM_SHIFT_BITS  shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out  output  NUM_BITS  shifted result.

Behaviour:
- Reset is asynchronous and active-low: rst_n low clears every stage valid immediately, without waiting for clk. Consequently out_valid = 0 and out = 0.
- Data registers are also cleared to 0 on reset, so out reads 0 at reset.
- Structure: NUM_SHIFT_BITS registered stages, indexed 0..NUM_SHIFT_BITS-1. Each stage holds valid, data, sh_type and the remaining shamt bits.
- Stage i computation, applied to the incoming data as it is loaded into stage i:
  - shamt[i] = 0: data passes through.
  - shamt[i] = 1, sh_type = 0: {data[NUM_BITS-1-2**i:0], (2**i) zeros}.
  - shamt[i] = 1, sh_type = 1: {data[NUM_BITS-1-2**i:0], data[NUM_BITS-1:NUM_BITS-2**i]}.
- Stage 0 loads from the input ports. Stage i loads from stage i-1.
- Output: out and out_valid come directly from the last stage's registers; there is no combinational path from in to out.
- Latency: a result appears NUM_SHIFT_BITS cycles after acceptance when there are no stalls (5 cycles for NUM_BITS=32).
- Throughput: 1 operation per cycle.
- Ready chain (bubble-collapsing):
  - ready_i = !valid_i || ready_{i+1}.
  - The last stage's ready = !out_valid || out_ready.
  - in_ready = ready_0, combinational from out_ready through the chain.
- Transfers: the input transfer occurs when in_valid && in_ready; the output transfer occurs when out_valid && out_ready.
- Stage load: a stage loads when its ready is 1. Its new valid is the upstream valid (in_valid for stage 0).
- Stall: a stalled stage holds its data and sh_type stable. While out_valid = 1 and out_ready = 0, out must not change.
- Full pipeline: all stages valid with out_ready = 0 gives in_ready = 0, and no operation is lost or duplicated.
- Empty pipeline: in_ready = 1 regardless of out_ready.
- Bubbles: an invalid stage is always overwritten, so gaps collapse while downstream is stalled.
- Flush:
  - On the flush edge, all valids become 0. Inputs presented in the same cycle are dropped, even if in_valid && in_ready.
  - in_ready is still computed normally during flush.
  - out_valid = 0 in the cycle after flush.
  - flush has priority over every load.
- Boundary values:
  - shamt = 0 returns in unchanged for both sh_type values.
  - shamt = NUM_BITS-1 with sh_type = 0 gives {in[0], zeros}.
  - Rotate-left by k equals (in << k) | (in >> (NUM_BITS-k)).
- Reset mid-operation discards all in-flight operations. After rst_n rises, in_ready = 1 and out_valid = 0.

Test Plan (NUM_BITS = 32):
- Single op: in = 32'h0000_00F1, shamt = 4, sh_type = 0, out_ready = 1 -> out_valid rises exactly 5 cycles after acceptance with out = 32'h0000_0F10; then out_valid = 0.
- Rotate: in = 32'hF000_000F, shamt = 8, sh_type = 1 -> out = 32'h0000_0FF0. Same operand with shamt = 31 -> out = 32'hF800_0007.
- Back-to-back: 64 random ops on consecutive cycles with out_ready = 1 -> 64 consecutive out_valid cycles, in order, each matching the reference model.
- Backpressure: stream ops while holding out_ready = 0 -> in_ready drops after exactly 5 accepts and out stays constant. Release out_ready with random toggling -> all 5 results drain in order, with no loss or duplication.
- Flush: flush for 1 cycle with 3 ops in flight and in_valid = 1 -> none of the 4 ops ever appears at the output. The next accepted op (in = 1, shamt = 31, sh_type = 0) gives out = 32'h8000_0000.
- Async reset: assert rst_n = 0 mid-stream between clock edges -> out_valid = 0 and out = 0 without waiting for clk. After release, in_ready = 1 and a new op completes with the normal 5-cycle latency.
